// File: rtl/mem_access_if.sv
// Cache request/response bus between the memory stage (master) and the data cache (slave).
interface mem_access_if #(
  parameter int unsigned ADDR_W = 30
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [3:0]        mem_req_wmask;
  logic [31:0]       mem_req_data;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wmask, mem_req_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wmask, mem_req_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I memory stage: issues one cache access per load/store, aligns load data for writeback.
// Optional MEM_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses with a one-cycle pulse.
module mem_access_stage #(
  parameter int unsigned ADDR_W = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_ex_valid,
  output logic        o_ex_ready,
  input  logic        i_ex_is_load,
  input  logic        i_ex_is_store,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_addr,
  input  logic [31:0] i_ex_store_data,
  input  logic [4:0]  i_ex_rd,
  mem_access_if.master mem,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_rd,
  output logic        o_misaligned
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_ex_ready;
  logic              w_req_valid;

  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_wmask;
  logic [31:0]       r_data;
  logic [1:0]        r_off;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic              r_is_store;
  logic              r_wb_valid;
  logic [31:0]       r_wb_data;
  logic [4:0]        r_wb_rd;

  logic              w_access;
  logic              w_block;
  logic [1:0]        w_off;
  logic [1:0]        w_eff_off;
  logic [3:0]        w_wmask;
  logic [31:0]       w_wdata;
  logic [31:0]       w_sh;
  logic [31:0]       w_load_data;

  assign w_access = i_ex_valid & (i_ex_is_load | i_ex_is_store);
  assign w_off    = i_ex_addr[1:0];

  // Natural alignment of the lane offset by access size
  always_comb begin
    w_eff_off = 2'b00;
    w_wmask   = 4'b0000;
    w_wdata   = 32'h0;
    case (i_ex_funct3[1:0])
      2'b00:   w_eff_off = w_off;
      2'b01:   w_eff_off = {w_off[1], 1'b0};
      default: w_eff_off = 2'b00;
    endcase
    if (i_ex_is_store) begin
      case (i_ex_funct3[1:0])
        2'b00: begin
          w_wmask = 4'b0001 << w_eff_off;
          w_wdata = {4{i_ex_store_data[7:0]}};
        end
        2'b01: begin
          w_wmask = 4'b0011 << w_eff_off;
          w_wdata = {2{i_ex_store_data[15:0]}};
        end
        default: begin
          w_wmask = 4'b1111;
          w_wdata = i_ex_store_data;
        end
      endcase
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic r_misaligned;
  always_comb begin
    w_block = 1'b0;
    case (i_ex_funct3[1:0])
      2'b00:   w_block = 1'b0;
      2'b01:   w_block = w_off[0];
      default: w_block = (w_off != 2'b00);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_misaligned <= 1'b0;
    else       r_misaligned <= (r_state == IDLE) && w_access && w_block;
  end
  assign o_misaligned = r_misaligned;
`else
  assign w_block      = 1'b0;
  assign o_misaligned = 1'b0;
`endif

  // Load extract and extend from the response word
  assign w_sh = mem.mem_resp_data >> {r_off, 3'b000};
  always_comb begin
    w_load_data = mem.mem_resp_data;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_load_data = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b100:  w_load_data = {24'h0, w_sh[7:0]};
      3'b101:  w_load_data = {16'h0, w_sh[15:0]};
      default: w_load_data = mem.mem_resp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_access && !w_block) w_state_nxt = REQ;
      REQ:  if (mem.mem_req_ready)    w_state_nxt = r_is_store ? IDLE : WAIT;
      WAIT: if (mem.mem_resp_valid)   w_state_nxt = IDLE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ex_ready  = 1'b0;
    w_req_valid = 1'b0;
    case (r_state)
      IDLE:    w_ex_ready  = 1'b1;
      REQ:     w_req_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture and writeback registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_wmask    <= 4'b0000;
      r_data     <= 32'h0;
      r_off      <= 2'b00;
      r_funct3   <= 3'b000;
      r_rd       <= 5'd0;
      r_is_store <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= 32'h0;
      r_wb_rd    <= 5'd0;
    end else begin
      r_wb_valid <= 1'b0;
      if ((r_state == IDLE) && w_access && !w_block) begin
        r_addr     <= i_ex_addr[ADDR_W+1:2];
        r_wmask    <= w_wmask;
        r_data     <= w_wdata;
        r_off      <= w_eff_off;
        r_funct3   <= i_ex_funct3;
        r_rd       <= i_ex_rd;
        r_is_store <= i_ex_is_store;
      end
      if ((r_state == WAIT) && mem.mem_resp_valid) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= w_load_data;
        r_wb_rd    <= r_rd;
      end
    end
  end

  assign o_ex_ready         = w_ex_ready;
  assign mem.mem_req_valid  = w_req_valid;
  assign mem.mem_req_addr   = r_addr;
  assign mem.mem_req_wmask  = r_wmask;
  assign mem.mem_req_data   = r_data;
  assign o_wb_valid         = r_wb_valid;
  assign o_wb_data          = r_wb_data;
  assign o_wb_rd            = r_wb_rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected requests/writebacks queued at drive time.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_ready, wb_valid, misaligned;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  wmask;
    logic [31:0] data;
    logic        chk_data;
  } req_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_exp_t;

  req_exp_t req_q[$];
  wb_exp_t  wb_q[$];

  mem_access_if #(.ADDR_W(30)) mem_if ();

  mem_access_stage #(.ADDR_W(30)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_ex_valid      (ex_valid),
    .o_ex_ready      (ex_ready),
    .i_ex_is_load    (ex_is_load),
    .i_ex_is_store   (ex_is_store),
    .i_ex_funct3     (ex_funct3),
    .i_ex_addr       (ex_addr),
    .i_ex_store_data (ex_store_data),
    .i_ex_rd         (ex_rd),
    .mem             (mem_if.master),
    .o_wb_valid      (wb_valid),
    .o_wb_data       (wb_data),
    .o_wb_rd         (wb_rd),
    .o_misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare on completed handshakes and writeback pulses
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_if.mem_req_valid && mem_if.mem_req_ready) begin
        if (req_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
        else begin
          req_exp_t e;
          e = req_q.pop_front();
          check("req_addr", 32'(mem_if.mem_req_addr), 32'(e.addr));
          check("req_wmask", 32'(mem_if.mem_req_wmask), 32'(e.wmask));
          if (e.chk_data) check("req_data", mem_if.mem_req_data, e.data);
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
        else begin
          wb_exp_t w;
          w = wb_q.pop_front();
          check("wb_data", wb_data, w.data);
          check("wb_rd", 32'(wb_rd), 32'(w.rd));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!ex_ready && n < 50) begin
      tick();
      n++;
    end
    if (!ex_ready) check("idle_timeout", 32'(ex_ready), 32'd1);
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = a; ex_store_data = d; ex_rd = rd;
  endtask

  // Hold ready low; fields must stay stable and a stray response must be ignored
  task automatic stall(input int cycles, input logic [29:0] a, input logic [3:0] m);
    for (int k = 0; k < cycles; k++) begin
      mem_if.mem_req_ready  = 1'b0;
      mem_if.mem_resp_valid = (k == 0);
      mem_if.mem_resp_data  = 32'hBAD0BAD0;
      tick();
      mem_if.mem_resp_valid = 1'b0;
      check("stall_addr", 32'(mem_if.mem_req_addr), 32'(a));
      check("stall_wmask", 32'(mem_if.mem_req_wmask), 32'(m));
      check("stall_ready", 32'(ex_ready), 32'd0);
      check("stall_req_valid", 32'(mem_if.mem_req_valid), 32'd1);
    end
  endtask

  task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                          input logic [31:0] word, input logic [31:0] exp_wb,
                          input int rdly, input int wdly);
    req_exp_t r;
    wb_exp_t  w;
    wait_idle();
    drive(1'b1, 1'b0, f3, a, 32'h0, rd);
    r = '{a[31:2], 4'b0000, 32'h0, 1'b0};
    w = '{exp_wb, rd};
    req_q.push_back(r);
    wb_q.push_back(w);
    tick();
    ex_valid = 1'b0;
    check("ld_req_valid", 32'(mem_if.mem_req_valid), 32'd1);
    stall(rdly, a[31:2], 4'b0000);
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_req_ready = 1'b0;
    repeat (wdly) tick();
    mem_if.mem_resp_valid = 1'b1;
    mem_if.mem_resp_data  = word;
    tick();
    mem_if.mem_resp_valid = 1'b0;
    check("ld_wb_valid", 32'(wb_valid), 32'd1);
    check("ld_ex_ready", 32'(ex_ready), 32'd1);
  endtask

  task automatic run_store(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] exp_m,
                           input logic [31:0] exp_d, input int rdly);
    req_exp_t r;
    wait_idle();
    drive(ld, 1'b1, f3, a, d, 5'd3);
    r = '{a[31:2], exp_m, exp_d, 1'b1};
    req_q.push_back(r);
    tick();
    ex_valid = 1'b0;
    check("st_ex_ready_busy", 32'(ex_ready), 32'd0);
    stall(rdly, a[31:2], exp_m);
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_req_ready = 1'b0;
    check("st_ex_ready_back", 32'(ex_ready), 32'd1);
    check("st_no_wb", 32'(wb_valid), 32'd0);
  endtask

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = w[8*{off[1], 1'b0} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = 3'b000; ex_addr = 32'h0; ex_store_data = 32'h0; ex_rd = 5'd0;
    mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_valid = 1'b0; mem_if.mem_resp_data = 32'h0;
    tick();
    tick();
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_req_valid", 32'(mem_if.mem_req_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    reset = 1'b0;

    run_load(3'b010, 32'h0000_1000, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 1);
    run_load(3'b000, 32'h0000_1003, 5'd6,  32'h80FFFFFF, 32'hFFFFFF80, 0, 0);
    run_load(3'b100, 32'h0000_1003, 5'd7,  32'h80FFFFFF, 32'h00000080, 0, 2);
    run_load(3'b101, 32'h0000_1002, 5'd8,  32'h80FFFFFF, 32'h000080FF, 0, 0);
    run_load(3'b001, 32'h0000_1002, 5'd9,  32'h80FFFFFF, 32'hFFFF80FF, 0, 0);
    run_load(3'b001, 32'h0000_1000, 5'd10, 32'h1234_8001, 32'hFFFF8001, 5, 1);

    run_store(1'b0, 3'b000, 32'h0000_2001, 32'h0000_00AB, 4'b0010, 32'hABABABAB, 0);
    run_store(1'b0, 3'b001, 32'h0000_2002, 32'h1234_CDEF, 4'b1100, 32'hCDEFCDEF, 0);
    run_store(1'b0, 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 4'b1111, 32'hCAFEF00D, 2);
    run_store(1'b1, 3'b000, 32'h0000_2003, 32'h0000_0012, 4'b1000, 32'h12121212, 0);

    // Neither load nor store: ignored
    wait_idle();
    drive(1'b0, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd1);
    tick();
    ex_valid = 1'b0;
    check("nop_ex_ready", 32'(ex_ready), 32'd1);
    check("nop_req_valid", 32'(mem_if.mem_req_valid), 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
    wait_idle();
    drive(1'b0, 1'b1, 3'b010, 32'h0000_3002, 32'h5566_7788, 5'd1);
    tick();
    ex_valid = 1'b0;
    check("mis_pulse", 32'(misaligned), 32'd1);
    check("mis_no_req", 32'(mem_if.mem_req_valid), 32'd0);
    check("mis_ex_ready", 32'(ex_ready), 32'd1);
    tick();
    check("mis_pulse_end", 32'(misaligned), 32'd0);
    check("mis_no_req2", 32'(mem_if.mem_req_valid), 32'd0);
`else
    run_store(1'b0, 3'b010, 32'h0000_3002, 32'h5566_7788, 4'b1111, 32'h55667788, 0);
    check("mis_tied", 32'(misaligned), 32'd0);
`endif

    // Reset while waiting for a load response
    wait_idle();
    begin
      req_exp_t r;
      drive(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd7);
      r = '{30'h1000, 4'b0000, 32'h0, 1'b0};
      req_q.push_back(r);
    end
    tick();
    ex_valid = 1'b0;
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_req_ready = 1'b0;
    check("wait_ex_ready", 32'(ex_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_ex_ready", 32'(ex_ready), 32'd1);
    check("mrst_req_valid", 32'(mem_if.mem_req_valid), 32'd0);
    check("mrst_req_addr", 32'(mem_if.mem_req_addr), 32'd0);
    check("mrst_wmask", 32'(mem_if.mem_req_wmask), 32'd0);
    check("mrst_req_data", mem_if.mem_req_data, 32'd0);
    check("mrst_wb_valid", 32'(wb_valid), 32'd0);
    check("mrst_wb_data", wb_data, 32'd0);
    check("mrst_wb_rd", 32'(wb_rd), 32'd0);
    mem_if.mem_resp_valid = 1'b1;
    mem_if.mem_resp_data  = 32'h0BAD_F00D;
    tick();
    mem_if.mem_resp_valid = 1'b0;
    check("mrst_no_wb", 32'(wb_valid), 32'd0);
    tick();
    check("mrst_no_wb2", 32'(wb_valid), 32'd0);

    // Random naturally aligned loads against the bench model
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, w;
      logic [2:0]  sel;
      sel = 3'($urandom_range(0, 4));
      case (sel)
        3'd0:    f3 = 3'b000;
        3'd1:    f3 = 3'b001;
        3'd2:    f3 = 3'b010;
        3'd3:    f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      a = $urandom & 32'h0000_FFFC;
      if (f3[1:0] == 2'b00)      a[1:0] = 2'($urandom_range(0, 3));
      else if (f3[1:0] == 2'b01) a[1]   = 1'($urandom_range(0, 1));
      w = $urandom;
      run_load(f3, a, 5'(i + 11), w, load_model(f3, a[1:0], w),
               $urandom_range(0, 2), $urandom_range(0, 2));
    end

    tick();
    tick();
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("wb_q_drained", 32'(wb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
